xf100_exu_wbck_arb: RTL and testbench

//   Writeback arbiter directly upstream of xf100_exu_wbck.

---
 rtl/xf100_exu_wbck_arb.sv | 117 +++++++++++
 tb/tb_xf100_exu_wbck_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xf100_exu_wbck_arb.sv
`default_nettype none
// ============================================================================
// Module   : xf100_exu_wbck_arb
// Brief    : Writeback arbiter merging the ALU result path and the buffered
//            long-pipe (LSU/MULDIV) result path into one registered regfile
//            write. Optional x0-write suppression via XF100_WBCK_X0_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module xf100_exu_wbck_arb #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int LP_DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   alu_wbck_valid,
    output logic                   alu_wbck_ready,
    input  logic [XLEN-1:0]        alu_wbck_data,
    input  logic [RFIDX_WIDTH-1:0] alu_wbck_rdidx,

    input  logic                   lp_wbck_valid,
    output logic                   lp_wbck_ready,
    input  logic [XLEN-1:0]        lp_wbck_data,
    input  logic [RFIDX_WIDTH-1:0] lp_wbck_rdidx,

    output logic                   wbck_o_wbck_en,
    output logic [XLEN-1:0]        wbck_o_wbck_data,
    output logic [RFIDX_WIDTH-1:0] wbck_o_wbck_rdidx,

    output logic                   lp_pending
);

    localparam int                 c_ptr_w   = $clog2(LP_DEPTH);
    localparam int                 c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(LP_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [XLEN-1:0]        r_lp_data  [LP_DEPTH];
    logic [RFIDX_WIDTH-1:0] r_lp_rdidx [LP_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;

    logic                   w_lp_fire;
    logic                   w_alu_fire;
    logic                   w_pop;
    logic                   w_sel_valid;
    logic [XLEN-1:0]        w_sel_data;
    logic [RFIDX_WIDTH-1:0] w_sel_rdidx;
    logic                   w_wr_en;

    // Readies look only at registered occupancy, never at the valids.
    assign lp_wbck_ready  = (r_count != c_depth);
    assign alu_wbck_ready = (r_count == '0);
    assign lp_pending     = (r_count != '0);

    assign w_lp_fire   = lp_wbck_valid && lp_wbck_ready;
    assign w_alu_fire  = alu_wbck_valid && alu_wbck_ready;
    assign w_pop       = (r_count != '0);

    // Buffered long-pipe results are older than anything the ALU can offer.
    assign w_sel_valid = w_pop || w_alu_fire;
    assign w_sel_data  = w_pop ? r_lp_data[r_rd_ptr]  : alu_wbck_data;
    assign w_sel_rdidx = w_pop ? r_lp_rdidx[r_rd_ptr] : alu_wbck_rdidx;

`ifdef XF100_WBCK_X0_FILTER_EN
    assign w_wr_en = w_sel_valid && (w_sel_rdidx != '0);
`else
    assign w_wr_en = w_sel_valid;
`endif

    always_ff @(posedge clk) begin
        if (w_lp_fire) begin
            r_lp_data[r_wr_ptr]  <= lp_wbck_data;
            r_lp_rdidx[r_wr_ptr] <= lp_wbck_rdidx;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_lp_fire) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_lp_fire, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbck_o_wbck_en    <= 1'b0;
            wbck_o_wbck_data  <= '0;
            wbck_o_wbck_rdidx <= '0;
        end else begin
            wbck_o_wbck_en <= w_wr_en;
            if (w_wr_en) begin
                wbck_o_wbck_data  <= w_sel_data;
                wbck_o_wbck_rdidx <= w_sel_rdidx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xf100_exu_wbck_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_xf100_exu_wbck_arb
// Brief    : Self-checking bench for xf100_exu_wbck_arb (ordering scoreboard,
//            occupancy model, per-scenario latency checks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xf100_exu_wbck_arb;

    localparam int XLEN  = 32;
    localparam int RFW   = 5;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alu_wbck_valid = 1'b0;
    logic            alu_wbck_ready;
    logic [XLEN-1:0] alu_wbck_data  = '0;
    logic [RFW-1:0]  alu_wbck_rdidx = '0;
    logic            lp_wbck_valid  = 1'b0;
    logic            lp_wbck_ready;
    logic [XLEN-1:0] lp_wbck_data   = '0;
    logic [RFW-1:0]  lp_wbck_rdidx  = '0;
    logic            wbck_o_wbck_en;
    logic [XLEN-1:0] wbck_o_wbck_data;
    logic [RFW-1:0]  wbck_o_wbck_rdidx;
    logic            lp_pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference occupancy model and in-order write scoreboard
    int                    m_count = 0;
    bit                    m_init  = 1'b0;
    bit                    m_alu_fire;
    bit                    m_lp_fire;
    bit                    m_pop;
    logic [RFW+XLEN-1:0]   sb_q[$];
    logic [RFW+XLEN-1:0]   sb_e;

    xf100_exu_wbck_arb #(
        .XLEN        (XLEN),
        .RFIDX_WIDTH (RFW),
        .LP_DEPTH    (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .alu_wbck_valid    (alu_wbck_valid),
        .alu_wbck_ready    (alu_wbck_ready),
        .alu_wbck_data     (alu_wbck_data),
        .alu_wbck_rdidx    (alu_wbck_rdidx),
        .lp_wbck_valid     (lp_wbck_valid),
        .lp_wbck_ready     (lp_wbck_ready),
        .lp_wbck_data      (lp_wbck_data),
        .lp_wbck_rdidx     (lp_wbck_rdidx),
        .wbck_o_wbck_en    (wbck_o_wbck_en),
        .wbck_o_wbck_data  (wbck_o_wbck_data),
        .wbck_o_wbck_rdidx (wbck_o_wbck_rdidx),
        .lp_pending        (lp_pending)
    );

    always #5 clk = ~clk;

    function automatic bit is_written(input logic [RFW-1:0] rd);
`ifdef XF100_WBCK_X0_FILTER_EN
        return (rd != '0);
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_count = 0;
            sb_q.delete();
            m_init  = 1'b1;
        end else if (m_init) begin
            m_alu_fire = alu_wbck_valid && (m_count == 0);
            m_lp_fire  = lp_wbck_valid && (m_count != DEPTH);
            m_pop      = (m_count != 0);
            if (m_alu_fire && is_written(alu_wbck_rdidx))
                sb_q.push_back({alu_wbck_rdidx, alu_wbck_data});
            if (m_lp_fire && is_written(lp_wbck_rdidx))
                sb_q.push_back({lp_wbck_rdidx, lp_wbck_data});
            m_count = m_count + int'(m_lp_fire) - int'(m_pop);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            n_tests++;
            if (alu_wbck_ready !== (m_count == 0)) begin
                n_fail++;
                $display("FAIL alu_ready: got %b expected %b", alu_wbck_ready, (m_count == 0));
            end
            n_tests++;
            if (lp_wbck_ready !== (m_count != DEPTH)) begin
                n_fail++;
                $display("FAIL lp_ready: got %b expected %b", lp_wbck_ready, (m_count != DEPTH));
            end
            n_tests++;
            if (lp_pending !== (m_count != 0)) begin
                n_fail++;
                $display("FAIL lp_pending: got %b expected %b", lp_pending, (m_count != 0));
            end
            n_tests++;
            if (wbck_o_wbck_en === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got rd=%0d data=%h expected no write",
                             wbck_o_wbck_rdidx, wbck_o_wbck_data);
                end else begin
                    sb_e = sb_q.pop_front();
                    if ({wbck_o_wbck_rdidx, wbck_o_wbck_data} !== sb_e) begin
                        n_fail++;
                        $display("FAIL sb_write: got rd=%0d data=%h expected rd=%0d data=%h",
                                 wbck_o_wbck_rdidx, wbck_o_wbck_data,
                                 sb_e[RFW+XLEN-1:XLEN], sb_e[XLEN-1:0]);
                    end
                end
            end else if (wbck_o_wbck_en !== 1'b0) begin
                n_fail++;
                $display("FAIL en_known: got %b expected 0 or 1", wbck_o_wbck_en);
            end
        end
    end

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        alu_wbck_valid = 1'b1; alu_wbck_data = 32'h1111_1111; alu_wbck_rdidx = 5'd1;
        lp_wbck_valid  = 1'b1; lp_wbck_data  = 32'h2222_2222; lp_wbck_rdidx  = 5'd2;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({wbck_o_wbck_en, wbck_o_wbck_data, wbck_o_wbck_rdidx, lp_pending} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: got en=%b data=%h rd=%0d pend=%b expected all 0",
                     wbck_o_wbck_en, wbck_o_wbck_data, wbck_o_wbck_rdidx, lp_pending);
        end
        rst = 1'b0;
        alu_wbck_valid = 1'b0;
        lp_wbck_valid  = 1'b0;
        @(negedge clk);
        n_tests++;
        if (wbck_o_wbck_en !== 1'b0 || lp_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_hs: got en=%b pend=%b expected 0 0", wbck_o_wbck_en, lp_pending);
        end
    endtask

    task automatic test_alu_only;
        @(negedge clk);
        alu_wbck_valid = 1'b1; alu_wbck_data = 32'hDEAD_BEEF; alu_wbck_rdidx = 5'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (wbck_o_wbck_en !== 1'b1 || wbck_o_wbck_data !== alu_wbck_data ||
                wbck_o_wbck_rdidx !== alu_wbck_rdidx) begin
                n_fail++;
                $display("FAIL alu_latency[%0d]: got en=%b rd=%0d data=%h expected en=1 rd=%0d data=%h",
                         i, wbck_o_wbck_en, wbck_o_wbck_rdidx, wbck_o_wbck_data,
                         alu_wbck_rdidx, alu_wbck_data);
            end
            alu_wbck_data  = 32'h1000_0000 + 32'(i);
            alu_wbck_rdidx = 5'(i + 10);
        end
        @(negedge clk);
        alu_wbck_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (wbck_o_wbck_en !== 1'b0 || wbck_o_wbck_data !== 32'h1000_0003 ||
            wbck_o_wbck_rdidx !== 5'd13) begin
            n_fail++;
            $display("FAIL alu_idle_hold: got en=%b rd=%0d data=%h expected en=0 rd=13 data=10000003",
                     wbck_o_wbck_en, wbck_o_wbck_rdidx, wbck_o_wbck_data);
        end
    endtask

    task automatic test_lp_only;
        @(negedge clk);
        lp_wbck_valid = 1'b1; lp_wbck_data = 32'h1234_5678; lp_wbck_rdidx = 5'd7;
        @(negedge clk);
        lp_wbck_valid = 1'b0;
        n_tests++;
        if (lp_pending !== 1'b1 || wbck_o_wbck_en !== 1'b0) begin
            n_fail++;
            $display("FAIL lp_n1: got pend=%b en=%b expected pend=1 en=0", lp_pending, wbck_o_wbck_en);
        end
        @(negedge clk);
        n_tests++;
        if (wbck_o_wbck_en !== 1'b1 || wbck_o_wbck_rdidx !== 5'd7 ||
            wbck_o_wbck_data !== 32'h1234_5678 || lp_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL lp_n2: got en=%b rd=%0d data=%h pend=%b expected en=1 rd=7 data=12345678 pend=0",
                     wbck_o_wbck_en, wbck_o_wbck_rdidx, wbck_o_wbck_data, lp_pending);
        end
    endtask

    task automatic test_collision;
        @(negedge clk);
        alu_wbck_valid = 1'b1; alu_wbck_data = 32'hAAAA_0003; alu_wbck_rdidx = 5'd3;
        lp_wbck_valid  = 1'b1; lp_wbck_data  = 32'hBBBB_0009; lp_wbck_rdidx  = 5'd9;
        @(negedge clk);
        alu_wbck_valid = 1'b0;
        lp_wbck_valid  = 1'b0;
        n_tests++;
        if (wbck_o_wbck_en !== 1'b1 || wbck_o_wbck_rdidx !== 5'd3 || alu_wbck_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_first: got en=%b rd=%0d alu_rdy=%b expected en=1 rd=3 alu_rdy=0",
                     wbck_o_wbck_en, wbck_o_wbck_rdidx, alu_wbck_ready);
        end
        @(negedge clk);
        n_tests++;
        if (wbck_o_wbck_en !== 1'b1 || wbck_o_wbck_rdidx !== 5'd9 ||
            wbck_o_wbck_data !== 32'hBBBB_0009) begin
            n_fail++;
            $display("FAIL collide_second: got en=%b rd=%0d data=%h expected en=1 rd=9 data=bbbb0009",
                     wbck_o_wbck_en, wbck_o_wbck_rdidx, wbck_o_wbck_data);
        end
    endtask

    task automatic test_drain_wrap;
        logic [RFW-1:0] alu_rd [2]  = '{5'd20, 5'd21};
        logic [RFW-1:0] lp_rd  [3]  = '{5'd10, 5'd11, 5'd12};
        logic [RFW-1:0] exp_rd [5]  = '{5'd20, 5'd10, 5'd11, 5'd12, 5'd21};
        logic [XLEN-1:0] exp_dt [5] = '{32'hA000_0014, 32'hB000_000A, 32'hB000_000B,
                                        32'hB000_000C, 32'hA000_0015};
        bit   exp_ardy [5]          = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int   ai = 0;
        int   li = 0;
        bit   f_alu;
        bit   f_lp;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            alu_wbck_valid = (ai < 2);
            if (ai < 2) begin
                alu_wbck_rdidx = alu_rd[ai];
                alu_wbck_data  = 32'hA000_0000 | 32'(alu_rd[ai]);
            end
            lp_wbck_valid = (li < 3);
            if (li < 3) begin
                lp_wbck_rdidx = lp_rd[li];
                lp_wbck_data  = 32'hB000_0000 | 32'(lp_rd[li]);
            end
            n_tests++;
            if (alu_wbck_ready !== exp_ardy[i]) begin
                n_fail++;
                $display("FAIL drain_alu_rdy[%0d]: got %b expected %b", i, alu_wbck_ready, exp_ardy[i]);
            end
            f_alu = alu_wbck_valid && alu_wbck_ready;
            f_lp  = lp_wbck_valid && lp_wbck_ready;
            @(negedge clk);
            if (f_alu) ai++;
            if (f_lp)  li++;
            n_tests++;
            if (wbck_o_wbck_en !== 1'b1 || wbck_o_wbck_rdidx !== exp_rd[i] ||
                wbck_o_wbck_data !== exp_dt[i]) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got en=%b rd=%0d data=%h expected en=1 rd=%0d data=%h",
                         i, wbck_o_wbck_en, wbck_o_wbck_rdidx, wbck_o_wbck_data, exp_rd[i], exp_dt[i]);
            end
        end
        alu_wbck_valid = 1'b0;
        lp_wbck_valid  = 1'b0;
        @(negedge clk);
        n_tests++;
        if (wbck_o_wbck_en !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_done: got en=%b pending_sb=%0d expected en=0 pending_sb=0",
                     wbck_o_wbck_en, sb_q.size());
        end
    endtask

    task automatic test_x0;
        @(negedge clk);
        alu_wbck_valid = 1'b1; alu_wbck_data = 32'h0BAD_F00D; alu_wbck_rdidx = 5'd4;
        @(negedge clk);
        alu_wbck_data = 32'hFFFF_FFFF; alu_wbck_rdidx = 5'd0;
        n_tests++;
        if (wbck_o_wbck_en !== 1'b1 || wbck_o_wbck_rdidx !== 5'd4 || alu_wbck_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_setup: got en=%b rd=%0d alu_rdy=%b expected en=1 rd=4 alu_rdy=1",
                     wbck_o_wbck_en, wbck_o_wbck_rdidx, alu_wbck_ready);
        end
        @(negedge clk);
        alu_wbck_valid = 1'b0;
        n_tests++;
`ifdef XF100_WBCK_X0_FILTER_EN
        if (wbck_o_wbck_en !== 1'b0 || wbck_o_wbck_data !== 32'h0BAD_F00D || wbck_o_wbck_rdidx !== 5'd4) begin
`else
        if (wbck_o_wbck_en !== 1'b1 || wbck_o_wbck_data !== 32'hFFFF_FFFF || wbck_o_wbck_rdidx !== 5'd0) begin
`endif
            n_fail++;
            $display("FAIL x0_alu: got en=%b rd=%0d data=%h", wbck_o_wbck_en, wbck_o_wbck_rdidx, wbck_o_wbck_data);
        end
        lp_wbck_valid = 1'b1; lp_wbck_data = 32'h5555_0000; lp_wbck_rdidx = 5'd0;
        @(negedge clk);
        lp_wbck_valid = 1'b0;
        @(negedge clk);
        n_tests++;
`ifdef XF100_WBCK_X0_FILTER_EN
        if (wbck_o_wbck_en !== 1'b0 || wbck_o_wbck_data !== 32'h0BAD_F00D || lp_pending !== 1'b0) begin
`else
        if (wbck_o_wbck_en !== 1'b1 || wbck_o_wbck_data !== 32'h5555_0000 || lp_pending !== 1'b0) begin
`endif
            n_fail++;
            $display("FAIL x0_lp: got en=%b rd=%0d data=%h pend=%b",
                     wbck_o_wbck_en, wbck_o_wbck_rdidx, wbck_o_wbck_data, lp_pending);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        lp_wbck_valid = 1'b1; lp_wbck_data = 32'hCAFE_000F; lp_wbck_rdidx = 5'd15;
        @(negedge clk);
        lp_wbck_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (wbck_o_wbck_en !== 1'b0 || lp_pending !== 1'b0 || wbck_o_wbck_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got en=%b pend=%b data=%h expected en=0 pend=0 data=0",
                     wbck_o_wbck_en, lp_pending, wbck_o_wbck_data);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (wbck_o_wbck_en !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_discard: got en=%b pending_sb=%0d expected en=0 pending_sb=0",
                     wbck_o_wbck_en, sb_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_only();
        test_lp_only();
        test_collision();
        test_drain_wrap();
        test_x0();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
